// File: rtl/alu_req_sequencer.sv
// Round-robin front end for a shared combinational ALU. It accepts one op at a
// time from two requesters, runs plain ALU ops in one cycle and MUL as WIDTH
// shift-add passes, and then holds a registered result until it is consumed.
module alu_req_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FSW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FSW-1:0]   alu_fs,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_z
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;          // 0: req0 favoured on a tie
  logic             id_q, id_d;
  logic [3:0]       fs_q, fs_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;    // operand A; shifted left during MUL
  logic [WIDTH-1:0] mplier_q, mplier_d;  // operand B; shifted right during MUL
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_id_q, rsp_id_d;

  logic             gnt_any, gnt_id;
  logic [4:0]       sel_op;

  // Grant: a lone valid wins, a tie goes to the requester the pointer favours.
  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    gnt_id     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    sel_op     = gnt_id ? req1_op : req0_op;
    req0_ready = (state_q == StIdle) && gnt_any && !gnt_id;
    req1_ready = (state_q == StIdle) && gnt_any && gnt_id;
  end

  // Next-state, ALU drive and result capture.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    fs_d       = fs_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_z_d    = rsp_z_q;
    rsp_id_d   = rsp_id_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_fs     = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          id_d     = gnt_id;
          rr_d     = ~gnt_id;
          fs_d     = sel_op[3:0];
          mcand_d  = gnt_id ? req1_a : req0_a;
          mplier_d = gnt_id ? req1_b : req0_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = sel_op[4] ? StMul : StExec;
        end
      end
      StExec: begin
        alu_a      = mcand_q;
        alu_b      = mplier_q;
        alu_fs     = FSW'(fs_q);
        rsp_data_d = alu_out;
        rsp_z_d    = (alu_out == '0);
        rsp_id_d   = id_q;
        state_d    = StResp;
      end
      StMul: begin
        // One shift-add step per cycle through the ALU's ADD code.
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        acc_d    = alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          rsp_data_d = alu_out;
          rsp_z_d    = (alu_out == '0);
          rsp_id_d   = id_q;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      fs_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      fs_q       <= fs_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_z_q    <= rsp_z_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;

endmodule
